// File: rtl/restador_pipe.sv
// Two-stage pipelined unsigned add/subtract with sign-magnitude result, carry and zero flags.
// Stage 1 holds the raw adder sum; stage 2 is the output register with the sign-magnitude result.
module restador_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_signo,
  output logic             out_cout,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);
  localparam int unsigned SUM_W = WIDTH + 1;

  logic             s1_valid;
  logic [SUM_W-1:0] s1_sum;
  logic             s1_sel;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_free;
  logic             s1_adv;
  logic             in_xfer;
  logic [WIDTH-1:0] bx;
  logic [SUM_W-1:0] sum;
  logic             signo;
  logic [WIDTH-1:0] res;

  // Handshake: in_ready depends only on pipeline state and out_ready
  always_comb begin
    s2_free  = ~out_valid | out_ready;
    s1_adv   = s1_valid & s2_free;
    in_ready = rst_n & (~s1_valid | s1_adv);
    in_xfer  = in_valid & in_ready;
  end

  // Subtract is A + ~B + 1 on the same adder
  always_comb begin
    bx  = in_b ^ {WIDTH{in_sel}};
    sum = SUM_W'(in_a) + SUM_W'(bx) + SUM_W'(in_sel);
  end

  // A borrow on subtract means B > A; negate to get the magnitude
  always_comb begin
    signo = s1_sel & ~s1_sum[WIDTH];
    res   = signo ? WIDTH'(~s1_sum[WIDTH-1:0] + WIDTH'(1)) : s1_sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_sel   <= 1'b0;
      s1_tag   <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_sum   <= sum;
        s1_sel   <= in_sel;
        s1_tag   <= in_tag;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_signo <= 1'b0;
      out_cout  <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (s1_adv) begin
        out_valid <= 1'b1;
        out_res   <= res;
        out_signo <= signo;
        out_cout  <= s1_sum[WIDTH];
        out_zero  <= (res == '0);
        out_tag   <= s1_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restador_pipe.sv
// Self-checking bench for restador_pipe: directed cases plus randomized streaming with
// backpressure on 8-bit and 16-bit instances, checked against an arithmetic reference model.
module tb_restador_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        sg;
    logic        co;
    logic        z;
    logic [3:0]  tg;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, sel8, out_valid8, out_ready8, signo8, cout8, zero8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  tag8, otag8;

  logic        in_valid16, in_ready16, sel16, out_valid16, out_ready16, signo16, cout16, zero16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  tag16, otag16;

  int errors = 0;
  int checks = 0;

  restador_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_a(a8), .in_b(b8), .in_sel(sel8), .in_tag(tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_res(res8), .out_signo(signo8),
    .out_cout(cout8), .out_zero(zero8), .out_tag(otag8)
  );

  restador_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_a(a16), .in_b(b16), .in_sel(sel16), .in_tag(tag16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_res(res16), .out_signo(signo16),
    .out_cout(cout16), .out_zero(zero16), .out_tag(otag16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned arithmetic on the operands
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic sel, input logic [3:0] tag);
    exp_t e;
    longint unsigned s;
    longint unsigned m;
    m = 64'd1 << w;
    if (!sel) begin
      s    = 64'(a) + 64'(b);
      e.res = 32'(s % m);
      e.co  = (s >= m);
      e.sg  = 1'b0;
    end else if (a >= b) begin
      e.res = a - b;
      e.co  = 1'b1;
      e.sg  = 1'b0;
    end else begin
      e.res = b - a;
      e.co  = 1'b0;
      e.sg  = 1'b1;
    end
    e.z  = (e.res == 32'd0);
    e.tg = tag;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic sel, input logic [3:0] tag, input logic ordy);
    if (w == 8) begin
      in_valid8  = v;
      out_ready8 = ordy;
      if (v) begin a8 = a[7:0]; b8 = b[7:0]; sel8 = sel; tag8 = tag; end
      else begin a8 = 'x; b8 = 'x; sel8 = 'x; tag8 = 'x; end
    end else begin
      in_valid16  = v;
      out_ready16 = ordy;
      if (v) begin a16 = a[15:0]; b16 = b[15:0]; sel16 = sel; tag16 = tag; end
      else begin a16 = 'x; b16 = 'x; sel16 = 'x; tag16 = 'x; end
    end
  endtask

  task automatic sample(input int w, output logic ov, output logic ir, output exp_t o);
    if (w == 8) begin
      ov = out_valid8; ir = in_ready8;
      o.res = 32'(res8); o.sg = signo8; o.co = cout8; o.z = zero8; o.tg = otag8;
    end else begin
      ov = out_valid16; ir = in_ready16;
      o.res = 32'(res16); o.sg = signo16; o.co = cout16; o.z = zero16; o.tg = otag16;
    end
  endtask

  // Single operation with out_ready held high; result must appear exactly two cycles later
  task automatic issue_check(input int w, input logic [31:0] a, input logic [31:0] b,
                             input logic sel, input logic [3:0] tag);
    logic ov, ir;
    exp_t o;
    drive(w, 1'b1, a, b, sel, tag, 1'b1);
    @(negedge clk); sample(w, ov, ir, o);
    chk("issue_ready", 64'(ir), 64'(1));
    @(posedge clk); #1; drive(w, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1);
    @(negedge clk); sample(w, ov, ir, o);
    chk("issue_lat_early", 64'(ov), 64'(0));
    @(posedge clk); #1;
    @(negedge clk); sample(w, ov, ir, o);
    chk("issue_result", 64'({ov, o}), 64'({1'b1, model(w, a, b, sel, tag)}));
    @(posedge clk); #1;
  endtask

  // Random operations under random backpressure, scoreboarded in order
  task automatic stream(input int w, input int n, input int rdy_pct);
    exp_t q[$];
    exp_t o, prev, e;
    logic ov, ir, ordy, prev_stall, pend, ps;
    logic [31:0] pa, pb, mask;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; pend = 1'b0; prev_stall = 1'b0;
    pa = 32'd0; pb = 32'd0; ps = 1'b0; prev = '0;
    mask = (w == 8) ? 32'h0000_00FF : 32'h0000_FFFF;
    while (got < n && cyc < n * 20 + 100) begin
      if (!pend && sent < n && $urandom_range(0, 3) != 0) begin
        pa = $urandom & mask;
        pb = $urandom & mask;
        ps = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0: pb = pa;
          1: begin pa = 32'd0; pb = mask; end
          default: ;
        endcase
        pend = 1'b1;
      end
      ordy = (int'($urandom_range(0, 99)) < rdy_pct);
      drive(w, pend, pa, pb, ps, 4'(sent), ordy);
      @(negedge clk);
      sample(w, ov, ir, o);
      chk("stream_in_ready", 64'(ir), 64'((q.size() < 2) || ordy));
      if (prev_stall) chk("stream_hold", 64'({ov, o}), 64'({1'b1, prev}));
      if (q.size() == 0) chk("stream_spurious", 64'(ov), 64'(0));
      if (ov && ordy && q.size() != 0) begin
        e = q.pop_front();
        chk("stream_result", 64'(o), 64'(e));
        got++;
      end
      if (pend && ir) begin
        q.push_back(model(w, pa, pb, ps, 4'(sent)));
        sent++;
        pend = 1'b0;
      end
      prev_stall = ov && !ordy;
      prev = o;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_done", 64'(got), 64'(n));
    drive(w, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1);
  endtask

  initial begin
    logic ov, ir;
    exp_t o;

    // Reset with a valid operation presented
    rst_n = 1'b0;
    drive(16, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1);
    drive(8, 1'b1, 32'h55, 32'h22, 1'b0, 4'h7, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk); sample(8, ov, ir, o);
    chk("rst_in_ready8", 64'(ir), 64'(0));
    chk("rst_outputs8", 64'({ov, o}), 64'(0));
    sample(16, ov, ir, o);
    chk("rst_in_ready16", 64'(ir), 64'(0));
    chk("rst_outputs16", 64'({ov, o}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1);

    // Directed corner cases, 8-bit
    issue_check(8, 32'h05, 32'h03, 1'b1, 4'd1);
    issue_check(8, 32'h00, 32'hFF, 1'b1, 4'd2);
    issue_check(8, 32'h10, 32'h30, 1'b1, 4'd3);
    issue_check(8, 32'hFF, 32'h01, 1'b0, 4'd4);
    issue_check(8, 32'h7A, 32'h7A, 1'b1, 4'd5);

    // Reset with two operations in flight
    drive(8, 1'b1, 32'h20, 32'h01, 1'b0, 4'd10, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b1, 32'h40, 32'h02, 1'b1, 4'd11, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1);
    rst_n = 1'b0;
    #1; sample(8, ov, ir, o);
    chk("midrst_valid", 64'(ov), 64'(0));
    chk("midrst_in_ready", 64'(ir), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); sample(8, ov, ir, o);
    chk("midrst_no_stale", 64'(ov), 64'(0));
    @(posedge clk); #1;
    issue_check(8, 32'h33, 32'h11, 1'b1, 4'd12);

    // Streaming tags 0..15 with random backpressure
    stream(8, 16, 50);

    // 16-bit regression and random sweep
    issue_check(16, 32'h0001, 32'h8000, 1'b1, 4'd6);
    issue_check(16, 32'hFFFF, 32'hFFFF, 1'b0, 4'd7);
    stream(16, 400, 70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
